timers_timer3_acu: RTL and testbench

Parametrised angle-capture unit, successor to the Timer2 phase chain. It merges prescaler, phase-input digital filter, edge qualifier and angle counter into one block, adding configurable counter width and filter depth, both-edge mode, a compare flag, and a saturating overflow with re-arm. It sits in the timers subsystem between the engine phase pin and the SFR bank, and drives the ACR capture register and TCON3 flags.

---
 rtl/timers_timer3_acu_if.sv | 40 ++++
 rtl/timers_timer3_acu.sv | 132 +++++++++++++
 tb/tb_timers_timer3_acu.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timers_timer3_acu_if.sv
// SFR / pin bundle of the Timer3 angle-capture unit.
// The unit itself connects as "slave" and the SFR bank / pin side as "master".
interface timers_timer3_acu_if #(
    parameter int CNT_W = 24,
    parameter int DFP_W = 3
);
    logic             timers_timer3_pht_i;
    logic             timers_sfr_tcon3_tr3_i;
    logic [DFP_W-1:0] timers_sfr_tcon3_dfp_i;
    logic             timers_sfr_tcon3_dfsel_i;
    logic [1:0]       timers_sfr_tcon3_edsel_i;
    logic [CNT_W-1:0] timers_sfr_tcmp_i;
    logic             timers_sfr_tcon3_capf_clr_i;
    logic             timers_sfr_tcon3_ovf_clr_i;
    logic             timers_sfr_tcon3_cmpf_clr_i;
    logic [CNT_W-1:0] timers_sfr_acr_o;
    logic             timers_sfr_tcon3_capf_o;
    logic             timers_sfr_tcon3_ovf_o;
    logic             timers_sfr_tcon3_cmpf_o;
    logic             timers_timer3_irq_o;
    logic             timers_timer3_filt_o;

    modport slave (
        input  timers_timer3_pht_i, timers_sfr_tcon3_tr3_i, timers_sfr_tcon3_dfp_i,
               timers_sfr_tcon3_dfsel_i, timers_sfr_tcon3_edsel_i, timers_sfr_tcmp_i,
               timers_sfr_tcon3_capf_clr_i, timers_sfr_tcon3_ovf_clr_i,
               timers_sfr_tcon3_cmpf_clr_i,
        output timers_sfr_acr_o, timers_sfr_tcon3_capf_o, timers_sfr_tcon3_ovf_o,
               timers_sfr_tcon3_cmpf_o, timers_timer3_irq_o, timers_timer3_filt_o
    );

    modport master (
        output timers_timer3_pht_i, timers_sfr_tcon3_tr3_i, timers_sfr_tcon3_dfp_i,
               timers_sfr_tcon3_dfsel_i, timers_sfr_tcon3_edsel_i, timers_sfr_tcmp_i,
               timers_sfr_tcon3_capf_clr_i, timers_sfr_tcon3_ovf_clr_i,
               timers_sfr_tcon3_cmpf_clr_i,
        input  timers_sfr_acr_o, timers_sfr_tcon3_capf_o, timers_sfr_tcon3_ovf_o,
               timers_sfr_tcon3_cmpf_o, timers_timer3_irq_o, timers_timer3_filt_o
    );
endinterface

// File: rtl/timers_timer3_acu.sv
// Timer3 angle-capture unit: phase-pin synchroniser, prescaler, digital filter,
// edge qualifier and angle counter with capture, compare and saturating overflow.
module timers_timer3_acu #(
    parameter int CNT_W      = 24,
    parameter int FILT_DEPTH = 3,
    parameter int DFP_W      = 3
) (
    input  logic                 timers_timer3_clock_i,
    input  logic                 timers_timer3_reset_i_b,
    timers_timer3_acu_if.slave   bus
);
    localparam int               PSC_W    = (1 << DFP_W) - 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEAS} state_e;

    logic                  s1_q, s2_q;
    logic [PSC_W-1:0]      psc_q, psc_d;
    logic [FILT_DEPTH-1:0] fsh_q, fsh_d;
    logic                  filt_q, filt_d, filt_prev_q;
    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q, acr_q;
    logic                  capf_q, ovf_q, cmpf_q;

    logic                  tr3;
    logic [PSC_W-1:0]      psc_mask;
    logic                  tick, edge_det, in_meas;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  cap_evt, ovf_evt, cmp_evt;

    assign tr3 = bus.timers_sfr_tcon3_tr3_i;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        psc_d    = tr3 ? psc_q + 1'b1 : '0;
        // dfp low bits all ones marks a tick; dfp=0 yields an empty mask, i.e. every clock.
        psc_mask = ~({PSC_W{1'b1}} << bus.timers_sfr_tcon3_dfp_i);
        tick     = (psc_q & psc_mask) == psc_mask;

        fsh_d  = fsh_q;
        filt_d = filt_q;
        if (!bus.timers_sfr_tcon3_dfsel_i) begin
            filt_d = s2_q;
        end else if (tick) begin
            fsh_d = {fsh_q[FILT_DEPTH-2:0], s2_q};
            if (&fsh_d)       filt_d = 1'b1;
            else if (~|fsh_d) filt_d = 1'b0;
        end

        edge_det = (bus.timers_sfr_tcon3_edsel_i[0] &  filt_q & ~filt_prev_q)
                 | (bus.timers_sfr_tcon3_edsel_i[1] & ~filt_q &  filt_prev_q);

        cnt_inc = cnt_q + CNT_W'(1);
        in_meas = tr3 && (state_q == ST_MEAS);
        cap_evt = in_meas && edge_det;
        ovf_evt = in_meas && tick && !edge_det && (cnt_q == CNT_LAST);
        cmp_evt = in_meas && tick && !edge_det && (bus.timers_sfr_tcmp_i != '0)
                  && (cnt_inc == bus.timers_sfr_tcmp_i);
    end

    // NOTE: non-blocking assignments keep s1/s2 a genuine two-stage synchroniser chain.
    always_ff @(posedge timers_timer3_clock_i) begin
        if (!timers_timer3_reset_i_b) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            psc_q       <= '0;
            fsh_q       <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
        end else begin
            s1_q        <= bus.timers_timer3_pht_i;
            s2_q        <= s1_q;
            psc_q       <= psc_d;
            fsh_q       <= fsh_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
        end
    end

    always_ff @(posedge timers_timer3_clock_i) begin
        if (!timers_timer3_reset_i_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acr_q   <= '0;
            capf_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cmpf_q  <= 1'b0;
        end else begin
            // A set in the same cycle as a clear strobe wins.
            capf_q <= cap_evt | (capf_q & ~bus.timers_sfr_tcon3_capf_clr_i);
            ovf_q  <= ovf_evt | (ovf_q  & ~bus.timers_sfr_tcon3_ovf_clr_i);
            cmpf_q <= cmp_evt | (cmpf_q & ~bus.timers_sfr_tcon3_cmpf_clr_i);
            if (cap_evt) acr_q <= cnt_q + CNT_W'(tick);

            if (!tr3) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_ARM;
                    ST_ARM: begin
                        if (edge_det) begin
                            cnt_q   <= '0;
                            state_q <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        if (edge_det) begin
                            cnt_q <= '0;
                        end else if (tick) begin
                            if (cnt_q == CNT_LAST) begin
                                cnt_q   <= CNT_SAT;
                                state_q <= ST_ARM;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.timers_sfr_acr_o        = acr_q;
    assign bus.timers_sfr_tcon3_capf_o = capf_q;
    assign bus.timers_sfr_tcon3_ovf_o  = ovf_q;
    assign bus.timers_sfr_tcon3_cmpf_o = cmpf_q;
    assign bus.timers_timer3_irq_o     = capf_q | ovf_q | cmpf_q;
    assign bus.timers_timer3_filt_o    = filt_q;
endmodule

// File: tb/tb_timers_timer3_acu.sv
// Bench for timers_timer3_acu: directed timing checks plus randomized pin waveforms
// scored against expected periods derived from the pin schedule.
module tb_timers_timer3_acu;
    localparam int CNT_W      = 8;
    localparam int FILT_DEPTH = 3;
    localparam int DFP_W      = 3;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic dir_capf_clr = 1'b0;
    logic mon_clr = 1'b0;
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_q[$];

    timers_timer3_acu_if #(.CNT_W(CNT_W), .DFP_W(DFP_W)) bus ();

    timers_timer3_acu #(.CNT_W(CNT_W), .FILT_DEPTH(FILT_DEPTH), .DFP_W(DFP_W)) dut (
        .timers_timer3_clock_i   (clk),
        .timers_timer3_reset_i_b (rst_b),
        .bus                     (bus.slave)
    );

    assign bus.timers_sfr_tcon3_capf_clr_i = dir_capf_clr | mon_clr;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        clocks(2);
        rst_b = 1'b1;
    endtask

    task automatic config_unit(input int dfp, input bit dfsel, input logic [1:0] edsel,
                               input int tcmp);
        bus.timers_sfr_tcon3_dfp_i   = DFP_W'(dfp);
        bus.timers_sfr_tcon3_dfsel_i = dfsel;
        bus.timers_sfr_tcon3_edsel_i = edsel;
        bus.timers_sfr_tcmp_i        = CNT_W'(tcmp);
    endtask

    // Drives a pin waveform of ntog toggles (even count, so the pin ends low) and
    // predicts each capture as the tick distance between successive qualifying edges.
    task automatic run_batch(input int dfp, input bit dfsel, input logic [1:0] edsel,
                             input int ntog, input int fixed_len);
        int   step, t, last_t, len;
        bit   armed;
        logic lvl;
        step   = 1 << dfp;
        t      = 0;
        last_t = 0;
        armed  = 1'b0;
        lvl    = 1'b0;
        bus.timers_sfr_tcon3_tr3_i = 1'b0;
        config_unit(dfp, dfsel, edsel, 0);
        clocks(4);
        bus.timers_sfr_tcon3_tr3_i = 1'b1;
        clocks(3);
        for (int i = 0; i < ntog; i++) begin
            len = (fixed_len != 0 ? fixed_len : $urandom_range(10, 60)) * step;
            clocks(len);
            t  += len;
            lvl = ~lvl;
            bus.timers_timer3_pht_i = lvl;
            if ((lvl && edsel[0]) || (!lvl && edsel[1])) begin
                if (armed) exp_q.push_back((t - last_t) / step);
                armed  = 1'b1;
                last_t = t;
            end
        end
        clocks(20 * step + 20);
        check("batch_ovf_clear", 32'(bus.timers_sfr_tcon3_ovf_o), 0);
        check("batch_cmpf_clear", 32'(bus.timers_sfr_tcon3_cmpf_o), 0);
        bus.timers_sfr_tcon3_tr3_i = 1'b0;
    endtask

    // Scoreboard monitor: every capture flag pops one expected period, then clears the flag.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (mon_en && bus.timers_sfr_tcon3_capf_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_capture: acr=%0d with no expected period",
                             bus.timers_sfr_acr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard_acr", 32'(bus.timers_sfr_acr_o), 32'(e));
                end
                mon_clr = 1'b1;
                @(negedge clk);
                mon_clr = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.timers_timer3_pht_i          = 1'b0;
        bus.timers_sfr_tcon3_tr3_i       = 1'b0;
        bus.timers_sfr_tcon3_ovf_clr_i   = 1'b0;
        bus.timers_sfr_tcon3_cmpf_clr_i  = 1'b0;
        config_unit(0, 1'b0, 2'b01, 0);

        // Reset state
        do_reset();
        check("rst_acr",  32'(bus.timers_sfr_acr_o), 0);
        check("rst_capf", 32'(bus.timers_sfr_tcon3_capf_o), 0);
        check("rst_ovf",  32'(bus.timers_sfr_tcon3_ovf_o), 0);
        check("rst_cmpf", 32'(bus.timers_sfr_tcon3_cmpf_o), 0);
        check("rst_irq",  32'(bus.timers_timer3_irq_o), 0);
        check("rst_filt", 32'(bus.timers_timer3_filt_o), 0);

        // Bypass capture latency, period 100, flag clear
        bus.timers_sfr_tcon3_tr3_i = 1'b1;
        clocks(5);
        bus.timers_timer3_pht_i = 1'b1; clocks(50);
        bus.timers_timer3_pht_i = 1'b0; clocks(50);
        bus.timers_timer3_pht_i = 1'b1; clocks(3);
        check("cap_not_early", 32'(bus.timers_sfr_tcon3_capf_o), 0);
        clocks(1);
        check("cap_capf", 32'(bus.timers_sfr_tcon3_capf_o), 1);
        check("cap_acr_100", 32'(bus.timers_sfr_acr_o), 100);
        check("cap_irq", 32'(bus.timers_timer3_irq_o), 1);
        dir_capf_clr = 1'b1; clocks(1); dir_capf_clr = 1'b0;
        check("capf_cleared", 32'(bus.timers_sfr_tcon3_capf_o), 0);
        check("irq_cleared", 32'(bus.timers_timer3_irq_o), 0);

        // Filter: glitch rejected, 5-clock pulse passes after 2+3 clocks
        do_reset();
        config_unit(0, 1'b1, 2'b11, 0);
        bus.timers_timer3_pht_i    = 1'b0;
        bus.timers_sfr_tcon3_tr3_i = 1'b1;
        clocks(10);
        bus.timers_timer3_pht_i = 1'b1; clocks(2);
        bus.timers_timer3_pht_i = 1'b0; clocks(10);
        check("glitch_filt", 32'(bus.timers_timer3_filt_o), 0);
        check("glitch_capf", 32'(bus.timers_sfr_tcon3_capf_o), 0);
        bus.timers_timer3_pht_i = 1'b1; clocks(4);
        check("pulse_filt_early", 32'(bus.timers_timer3_filt_o), 0);
        clocks(1);
        check("pulse_filt_rise", 32'(bus.timers_timer3_filt_o), 1);
        bus.timers_timer3_pht_i = 1'b0; clocks(11);
        check("pulse_capf", 32'(bus.timers_sfr_tcon3_capf_o), 1);
        check("pulse_acr_5", 32'(bus.timers_sfr_acr_o), 5);

        // Overflow, re-arm without capture, then capture 40
        do_reset();
        config_unit(0, 1'b0, 2'b01, 0);
        bus.timers_sfr_tcon3_tr3_i = 1'b1;
        clocks(5);
        bus.timers_timer3_pht_i = 1'b1; clocks(300);
        check("ovf_set", 32'(bus.timers_sfr_tcon3_ovf_o), 1);
        check("ovf_acr_held", 32'(bus.timers_sfr_acr_o), 0);
        check("ovf_no_capf", 32'(bus.timers_sfr_tcon3_capf_o), 0);
        check("ovf_irq", 32'(bus.timers_timer3_irq_o), 1);
        bus.timers_timer3_pht_i = 1'b0; clocks(20);
        bus.timers_timer3_pht_i = 1'b1; clocks(20);
        bus.timers_timer3_pht_i = 1'b0; clocks(19);
        check("rearm_no_capf", 32'(bus.timers_sfr_tcon3_capf_o), 0);
        clocks(1);
        bus.timers_timer3_pht_i = 1'b1; clocks(4);
        check("rearm_capf", 32'(bus.timers_sfr_tcon3_capf_o), 1);
        check("rearm_acr_40", 32'(bus.timers_sfr_acr_o), 40);
        bus.timers_sfr_tcon3_ovf_clr_i = 1'b1; clocks(1);
        bus.timers_sfr_tcon3_ovf_clr_i = 1'b0;
        check("ovf_cleared", 32'(bus.timers_sfr_tcon3_ovf_o), 0);

        // Compare at tick 30, and set beating a same-cycle clear
        do_reset();
        config_unit(0, 1'b0, 2'b01, 30);
        bus.timers_timer3_pht_i    = 1'b0;
        bus.timers_sfr_tcon3_tr3_i = 1'b1;
        clocks(5);
        bus.timers_timer3_pht_i = 1'b1; clocks(33);
        check("cmp_not_early", 32'(bus.timers_sfr_tcon3_cmpf_o), 0);
        clocks(1);
        check("cmp_set", 32'(bus.timers_sfr_tcon3_cmpf_o), 1);
        bus.timers_sfr_tcon3_cmpf_clr_i = 1'b1; clocks(1);
        bus.timers_sfr_tcon3_cmpf_clr_i = 1'b0;
        check("cmp_cleared", 32'(bus.timers_sfr_tcon3_cmpf_o), 0);
        clocks(15);
        bus.timers_timer3_pht_i = 1'b0; clocks(50);
        bus.timers_timer3_pht_i = 1'b1; clocks(33);
        bus.timers_sfr_tcon3_cmpf_clr_i = 1'b1; clocks(1);
        bus.timers_sfr_tcon3_cmpf_clr_i = 1'b0;
        check("cmp_set_beats_clr", 32'(bus.timers_sfr_tcon3_cmpf_o), 1);
        check("cmp_acr_100", 32'(bus.timers_sfr_acr_o), 100);

        // tr3 dropped mid-period discards it; fresh arming edge required
        do_reset();
        config_unit(0, 1'b0, 2'b01, 0);
        bus.timers_timer3_pht_i    = 1'b0;
        bus.timers_sfr_tcon3_tr3_i = 1'b1;
        clocks(5);
        bus.timers_timer3_pht_i = 1'b1; clocks(50);
        bus.timers_timer3_pht_i = 1'b0; clocks(14);
        bus.timers_sfr_tcon3_tr3_i = 1'b0; clocks(6);
        bus.timers_sfr_tcon3_tr3_i = 1'b1; clocks(30);
        bus.timers_timer3_pht_i = 1'b1; clocks(10);
        check("tr3_drop_no_capf", 32'(bus.timers_sfr_tcon3_capf_o), 0);
        clocks(20);
        bus.timers_timer3_pht_i = 1'b0; clocks(40);
        bus.timers_timer3_pht_i = 1'b1; clocks(4);
        check("tr3_capf", 32'(bus.timers_sfr_tcon3_capf_o), 1);
        check("tr3_acr_70", 32'(bus.timers_sfr_acr_o), 70);

        // Reset asserted mid-period clears everything next cycle
        clocks(20);
        rst_b = 1'b0; clocks(1);
        check("midrst_acr",  32'(bus.timers_sfr_acr_o), 0);
        check("midrst_capf", 32'(bus.timers_sfr_tcon3_capf_o), 0);
        check("midrst_ovf",  32'(bus.timers_sfr_tcon3_ovf_o), 0);
        check("midrst_cmpf", 32'(bus.timers_sfr_tcon3_cmpf_o), 0);
        check("midrst_irq",  32'(bus.timers_timer3_irq_o), 0);
        check("midrst_filt", 32'(bus.timers_timer3_filt_o), 0);
        rst_b = 1'b1;

        // Scoreboarded waveforms: prescaled periods, both-edge mode, then random mixes
        bus.timers_timer3_pht_i    = 1'b0;
        bus.timers_sfr_tcon3_tr3_i = 1'b0;
        clocks(40);
        do_reset();
        mon_en = 1'b1;
        run_batch(2, 1'b0, 2'b01, 6, 50);
        run_batch(2, 1'b0, 2'b11, 6, 50);
        for (int b = 0; b < 8; b++) begin
            run_batch($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      2'($urandom_range(1, 3)), 2 * $urandom_range(2, 4), 0);
        end
        clocks(10);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
